// File: rtl/hazard_unit_if.sv
// Hazard-unit bundle: decode-stage hazard descriptors in, stall and
// forwarding-mux selects out. The controller side drives the descriptors;
// the hazard unit drives the decisions.
interface hazard_if;
    logic [4:0] Rs_D;
    logic [4:0] Rt_D;
    logic [4:0] A3_D;
    logic [1:0] Tnew_D;
    logic [1:0] Tuse_Rs_D;
    logic [1:0] Tuse_Rt_D;
    logic       isRead_Rs;
    logic       isRead_Rt;
    logic       stall;
    logic [1:0] FwdRs_D;
    logic [1:0] FwdRt_D;
    logic [1:0] FwdRs_E;
    logic [1:0] FwdRt_E;
    logic       FwdRt_M;

    modport master (
        output Rs_D, Rt_D, A3_D, Tnew_D, Tuse_Rs_D, Tuse_Rt_D, isRead_Rs, isRead_Rt,
        input  stall, FwdRs_D, FwdRt_D, FwdRs_E, FwdRt_E, FwdRt_M
    );

    modport slave (
        input  Rs_D, Rt_D, A3_D, Tnew_D, Tuse_Rs_D, Tuse_Rt_D, isRead_Rs, isRead_Rt,
        output stall, FwdRs_D, FwdRt_D, FwdRs_E, FwdRt_E, FwdRt_M
    );
endinterface

// File: rtl/hazard_unit.sv
// Pipeline hazard tracker for the five-stage core. Shadows the destination
// and remaining Tnew of every in-flight instruction through E/M/W and derives
// the decode stall plus the D/E/M forwarding selects from them.
module hazard_unit (
    input  logic     clk,
    input  logic     reset,
    hazard_if.slave  hz
);

    logic [4:0] A3_E_q, A3_E_d;
    logic [1:0] Tnew_E_q, Tnew_E_d;
    logic [4:0] Rs_E_q, Rs_E_d;
    logic [4:0] Rt_E_q, Rt_E_d;
    logic [4:0] A3_M_q, A3_M_d;
    logic [1:0] Tnew_M_q, Tnew_M_d;
    logic [4:0] Rt_M_q, Rt_M_d;
    logic [4:0] A3_W_q, A3_W_d;

    logic stall_rs;
    logic stall_rt;

    // One cycle of progress: remaining latency shrinks by one, never below 0.
    function automatic logic [1:0] sat_dec(input logic [1:0] x);
        return (x != 2'd0) ? (x - 2'd1) : 2'd0;
    endfunction

    // A source register must wait if a producer in E or M will not have its
    // result by the time the consumer needs it.
    function automatic logic need_stall(input logic rd, input logic [4:0] r,
                                        input logic [1:0] tuse,
                                        input logic [4:0] a3e, input logic [1:0] tne,
                                        input logic [4:0] a3m, input logic [1:0] tnm);
        return rd && (r != 5'd0) &&
               (((a3e == r) && (tne > tuse)) || ((a3m == r) && (tnm > tuse)));
    endfunction

    // Youngest ready producer wins; a not-ready younger match falls through
    // to an older ready one (the stall logic covers the unsafe cases).
    function automatic logic [1:0] fwd_d(input logic [4:0] r,
                                         input logic [4:0] a3e, input logic [1:0] tne,
                                         input logic [4:0] a3m, input logic [1:0] tnm,
                                         input logic [4:0] a3w);
        if (r == 5'd0)                      return 2'd0;
        else if ((a3e == r) && (tne == 0))  return 2'd1;
        else if ((a3m == r) && (tnm == 0))  return 2'd2;
        else if (a3w == r)                  return 2'd3;
        else                                return 2'd0;
    endfunction

    function automatic logic [1:0] fwd_e(input logic [4:0] r,
                                         input logic [4:0] a3m, input logic [1:0] tnm,
                                         input logic [4:0] a3w);
        if (r == 5'd0)                      return 2'd0;
        else if ((a3m == r) && (tnm == 0))  return 2'd2;
        else if (a3w == r)                  return 2'd3;
        else                                return 2'd0;
    endfunction

    // Stall and forwarding decisions from shadow state and the D descriptors.
    always_comb begin
        stall_rs   = need_stall(hz.isRead_Rs, hz.Rs_D, hz.Tuse_Rs_D,
                                A3_E_q, Tnew_E_q, A3_M_q, Tnew_M_q);
        stall_rt   = need_stall(hz.isRead_Rt, hz.Rt_D, hz.Tuse_Rt_D,
                                A3_E_q, Tnew_E_q, A3_M_q, Tnew_M_q);
        hz.stall   = stall_rs | stall_rt;
        hz.FwdRs_D = fwd_d(hz.Rs_D, A3_E_q, Tnew_E_q, A3_M_q, Tnew_M_q, A3_W_q);
        hz.FwdRt_D = fwd_d(hz.Rt_D, A3_E_q, Tnew_E_q, A3_M_q, Tnew_M_q, A3_W_q);
        hz.FwdRs_E = fwd_e(Rs_E_q, A3_M_q, Tnew_M_q, A3_W_q);
        hz.FwdRt_E = fwd_e(Rt_E_q, A3_M_q, Tnew_M_q, A3_W_q);
        hz.FwdRt_M = (Rt_M_q != 5'd0) && (A3_W_q == Rt_M_q);
    end

    // Next shadow contents: M and W always advance; E takes D or a bubble.
    always_comb begin
        A3_M_d   = A3_E_q;
        Tnew_M_d = sat_dec(Tnew_E_q);
        Rt_M_d   = Rt_E_q;
        A3_W_d   = A3_M_q;
        A3_E_d   = 5'd0;
        Tnew_E_d = 2'd0;
        Rs_E_d   = 5'd0;
        Rt_E_d   = 5'd0;
        if (!hz.stall) begin
            A3_E_d   = hz.A3_D;
            Tnew_E_d = sat_dec(hz.Tnew_D);
            Rs_E_d   = hz.Rs_D;
            Rt_E_d   = hz.Rt_D;
        end
    end

    // Shadow register update with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            A3_E_q   <= 5'd0;
            Tnew_E_q <= 2'd0;
            Rs_E_q   <= 5'd0;
            Rt_E_q   <= 5'd0;
            A3_M_q   <= 5'd0;
            Tnew_M_q <= 2'd0;
            Rt_M_q   <= 5'd0;
            A3_W_q   <= 5'd0;
        end else begin
            A3_E_q   <= A3_E_d;
            Tnew_E_q <= Tnew_E_d;
            Rs_E_q   <= Rs_E_d;
            Rt_E_q   <= Rt_E_d;
            A3_M_q   <= A3_M_d;
            Tnew_M_q <= Tnew_M_d;
            Rt_M_q   <= Rt_M_d;
            A3_W_q   <= A3_W_d;
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: directed instruction sequences push their
// hand-derived outputs into a queue; a negedge monitor pops and compares.
module tb_hazard_unit;

    logic clk = 1'b0;
    logic reset;
    hazard_if hz();

    hazard_unit dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [9:0] vec;  // {stall, FwdRs_D, FwdRt_D, FwdRs_E, FwdRt_E, FwdRt_M}
    } exp_t;

    exp_t sb[$];
    int n_tests = 0;
    int n_fail  = 0;

    // Monitor: compare the settled outputs mid-cycle against the oldest expectation.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            logic [9:0] act;
            e   = sb.pop_front();
            act = {hz.stall, hz.FwdRs_D, hz.FwdRt_D, hz.FwdRs_E, hz.FwdRt_E, hz.FwdRt_M};
            n_tests++;
            if (act !== e.vec) begin
                n_fail++;
                $display("FAIL %s: got stall=%0d FRsD=%0d FRtD=%0d FRsE=%0d FRtE=%0d FRtM=%0d, expected stall=%0d FRsD=%0d FRtD=%0d FRsE=%0d FRtE=%0d FRtM=%0d",
                         e.name, act[9], act[8:7], act[6:5], act[4:3], act[2:1], act[0],
                         e.vec[9], e.vec[8:7], e.vec[6:5], e.vec[4:3], e.vec[2:1], e.vec[0]);
            end
        end
    end

    // Apply one D-stage cycle, record what the outputs must be, advance a clock.
    task automatic step(input string nm, input logic rst_n,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] a3,
                        input logic [1:0] tn, input logic [1:0] urs, input logic [1:0] urt,
                        input logic rrs, input logic rrt,
                        input logic est, input logic [1:0] ersd, input logic [1:0] ertd,
                        input logic [1:0] erse, input logic [1:0] erte, input logic ertm);
        exp_t e;
        reset        = rst_n;
        hz.Rs_D      = rs;
        hz.Rt_D      = rt;
        hz.A3_D      = a3;
        hz.Tnew_D    = tn;
        hz.Tuse_Rs_D = urs;
        hz.Tuse_Rt_D = urt;
        hz.isRead_Rs = rrs;
        hz.isRead_Rt = rrt;
        e.name = nm;
        e.vec  = {est, ersd, ertd, erse, erte, ertm};
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset held for two edges with random D inputs.
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            hz.Rs_D      = 5'($urandom);
            hz.Rt_D      = 5'($urandom);
            hz.A3_D      = 5'($urandom);
            hz.Tnew_D    = 2'($urandom);
            hz.Tuse_Rs_D = 2'($urandom);
            hz.Tuse_Rt_D = 2'($urandom);
            hz.isRead_Rs = 1'($urandom);
            hz.isRead_Rt = 1'($urandom);
            @(posedge clk);
            #1;
        end

        //    name          rst rs  rt  a3  tn urs urt rrs rrt  st rsd rtd rse rte rtm
        step("rst_idle",    1,  0,  0,  0,  0, 3, 3, 0, 0,   0, 0, 0, 0, 0, 0);
        step("rst_rd",      1,  8,  9,  0,  0, 0, 0, 1, 1,   0, 0, 0, 0, 0, 0);

        // Load-use: one-cycle stall, then W forwarding into E.
        step("lu_lw",       1, 29,  8,  8,  3, 1, 3, 1, 0,   0, 0, 0, 0, 0, 0);
        step("lu_stall",    1,  8, 10, 11,  1, 1, 1, 1, 1,   1, 0, 0, 0, 0, 0);
        step("lu_release",  1,  8, 10, 11,  1, 1, 1, 1, 1,   0, 0, 0, 0, 0, 0);
        step("lu_fwdE_W",   1,  0,  0,  0,  0, 3, 3, 0, 0,   0, 0, 0, 3, 0, 0);

        // ALU op then branch on its result.
        step("br_add",      1,  1,  2,  9,  2, 1, 1, 1, 1,   0, 0, 0, 0, 0, 0);
        step("br_stall",    1,  9,  9,  0,  0, 0, 0, 1, 1,   1, 0, 0, 0, 0, 0);
        step("br_fwdD_M",   1,  9,  9,  0,  0, 0, 0, 1, 1,   0, 2, 2, 0, 0, 0);
        step("br_fwdE_W",   1,  0,  0,  0,  0, 3, 3, 0, 0,   0, 0, 0, 3, 3, 0);

        // jal then jr $31.
        step("jal",         1,  0,  0, 31,  1, 3, 3, 0, 0,   0, 0, 0, 0, 0, 0);
        step("jr_fwdD_E",   1, 31,  0,  0,  0, 0, 3, 1, 0,   0, 1, 0, 0, 0, 0);
        step("jr_fwdE_M",   1,  0,  0,  0,  0, 3, 3, 0, 0,   0, 0, 0, 2, 0, 0);
        step("jr_drain",    1,  0,  0,  0,  0, 3, 3, 0, 0,   0, 0, 0, 0, 0, 0);

        // Load then store data: no stall, resolved in M.
        step("st_lw",       1, 29,  0,  5,  3, 1, 3, 1, 0,   0, 0, 0, 0, 0, 0);
        step("st_sw",       1, 29,  5,  0,  0, 1, 2, 1, 1,   0, 0, 0, 0, 0, 0);
        step("st_inE",      1,  0,  0,  0,  0, 3, 3, 0, 0,   0, 0, 0, 0, 0, 0);
        step("st_fwdM",     1,  0,  0,  0,  0, 3, 3, 0, 0,   0, 0, 0, 0, 0, 1);

        // $0 never stalls or forwards.
        step("z_wr0",       1,  0,  0,  0,  3, 3, 3, 0, 0,   0, 0, 0, 0, 0, 0);
        step("z_rd0",       1,  0,  0,  0,  0, 0, 0, 1, 1,   0, 0, 0, 0, 0, 0);
        step("z_drain",     1,  0,  0,  0,  0, 3, 3, 0, 0,   0, 0, 0, 0, 0, 0);

        // E and M both write $7 and both ready: E wins in D.
        step("pr_m",        1,  0,  0,  7,  0, 3, 3, 0, 0,   0, 0, 0, 0, 0, 0);
        step("pr_e",        1,  0,  0,  7,  1, 3, 3, 0, 0,   0, 0, 0, 0, 0, 0);
        step("pr_fwdD_E",   1,  7,  7,  0,  0, 0, 0, 1, 1,   0, 1, 1, 0, 0, 0);
        step("pr_fwdE_M",   1,  0,  0,  0,  0, 3, 3, 0, 0,   0, 0, 0, 2, 2, 0);
        step("pr_fwdM",     1,  0,  0,  0,  0, 3, 3, 0, 0,   0, 0, 0, 0, 0, 1);

        // Load then branch: two-cycle stall, then W forwarding in D.
        step("lb_lw",       1, 29,  0,  4,  3, 1, 3, 1, 0,   0, 0, 0, 0, 0, 0);
        step("lb_stall1",   1,  4,  0,  0,  0, 0, 3, 1, 0,   1, 0, 0, 0, 0, 0);
        step("lb_stall2",   1,  4,  0,  0,  0, 0, 3, 1, 0,   1, 0, 0, 0, 0, 0);
        step("lb_fwdD_W",   1,  4,  0,  0,  0, 0, 3, 1, 0,   0, 3, 0, 0, 0, 0);
        step("lb_drain",    1,  0,  0,  0,  0, 3, 3, 0, 0,   0, 0, 0, 0, 0, 0);

        // Reset asserted in the middle of a two-cycle stall.
        step("rs_lw",       1, 29,  0,  6,  3, 1, 3, 1, 0,   0, 0, 0, 0, 0, 0);
        step("rs_stall1",   1,  6,  0,  0,  0, 0, 3, 1, 0,   1, 0, 0, 0, 0, 0);
        step("rs_stall_rst",0,  6,  0,  0,  0, 0, 3, 1, 0,   1, 0, 0, 0, 0, 0);
        step("rs_cleared",  1,  6,  0,  0,  0, 0, 3, 1, 0,   0, 0, 0, 0, 0, 0);

        repeat (3) @(posedge clk);
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
